controle_multiciclo: RTL

Multicycle control unit for the 8-bit RISC-V datapath. It decodes the fetched instruction fields and sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK through a Moore state machine. It drives `ULAControl` into the ALU and consumes the ALU `Z` flag for branch resolution. Sits between the instruction register and the datapath muxes, register-file and memory enables.

---
 rtl/riscv_pkg.sv | 53 +++++
 rtl/controle_multiciclo_decodificador_ula.sv | 33 +++
 rtl/controle_multiciclo.sv | 131 +++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared encodings for the 8-bit RISC-V multicycle core: opcodes, FSM states,
// ALU operation codes and datapath mux selects.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef logic [3:0] state_t;
  localparam state_t S_FETCH    = 4'd0;
  localparam state_t S_DECODE   = 4'd1;
  localparam state_t S_MEMADR   = 4'd2;
  localparam state_t S_MEMREAD  = 4'd3;
  localparam state_t S_MEMWB    = 4'd4;
  localparam state_t S_MEMWRITE = 4'd5;
  localparam state_t S_EXECR    = 4'd6;
  localparam state_t S_EXECI    = 4'd7;
  localparam state_t S_ALUWB    = 4'd8;
  localparam state_t S_JAL      = 4'd9;
  localparam state_t S_BEQ      = 4'd10;

  localparam logic [2:0] ULA_ADD = 3'b000;
  localparam logic [2:0] ULA_SUB = 3'b001;
  localparam logic [2:0] ULA_AND = 3'b010;
  localparam logic [2:0] ULA_OR  = 3'b011;
  localparam logic [2:0] ULA_XOR = 3'b100;
  localparam logic [2:0] ULA_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REGA  = 2'b10;

  localparam logic [1:0] SRCB_WDATA = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/controle_multiciclo_decodificador_ula.sv
// ALU operation decoder: maps the FSM's ALUOp plus instruction fields to the
// ULAControl code. Purely combinational so a single-cycle core can reuse it.
module decodificador_ula
  import riscv_pkg::*;
(
  input  logic [1:0] aluOp_i,
  input  logic [2:0] funct3_i,
  input  logic       op5_i,
  input  logic       funct7b5_i,
  output logic [2:0] ulaControl_o
);

  // Only R-type (op[5]=1) with funct7b5 selects sub; addi ignores funct7b5.
  always_comb begin
    ulaControl_o = ULA_ADD;
    unique case (aluOp_i)
      ALUOP_ADD: ulaControl_o = ULA_ADD;
      ALUOP_SUB: ulaControl_o = ULA_SUB;
      ALUOP_FUNCT: begin
        unique case (funct3_i)
          3'b000:  ulaControl_o = (op5_i && funct7b5_i) ? ULA_SUB : ULA_ADD;
          3'b010:  ulaControl_o = ULA_SLT;
          3'b100:  ulaControl_o = ULA_XOR;
          3'b110:  ulaControl_o = ULA_OR;
          3'b111:  ulaControl_o = ULA_AND;
          default: ulaControl_o = ULA_ADD;
        endcase
      end
      default: ulaControl_o = ULA_ADD;
    endcase
  end

endmodule

// File: rtl/controle_multiciclo.sv
// Multicycle control unit: Moore FSM sequencing FETCH/DECODE/EXECUTE/MEMORY/
// WRITEBACK and driving the datapath selects, enables and ALU control.
module controle_multiciclo
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Z,
  output logic [2:0] ULAControl,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       PCWrite,
  output logic       illegal
);

  state_t     state_q, state_d;
  logic [1:0] aluOp;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = S_FETCH;
    aluOp     = ALUOP_ADD;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_WDATA;
    ResultSrc = RES_ALUOUT;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    MemWrite  = 1'b0;
    RegWrite  = 1'b0;
    PCWrite   = 1'b0;
    illegal   = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        IRWrite   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        PCWrite   = 1'b1;
        state_d   = S_DECODE;
      end
      // OldPC + ImmExt precomputes the branch/jump target while decoding.
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        unique case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_JAL:            state_d = S_JAL;
          OP_BRANCH:         state_d = S_BEQ;
          default: begin
            state_d = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_REGA;
        ALUSrcB = SRCB_IMM;
        state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_REGA;
        aluOp   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_REGA;
        ALUSrcB = SRCB_IMM;
        aluOp   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: RegWrite = 1'b1;
      S_JAL: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        PCWrite = 1'b1;
        state_d = S_ALUWB;
      end
      // The only Mealy-style output: PCWrite follows Z in this very cycle.
      S_BEQ: begin
        ALUSrcA = SRCA_REGA;
        aluOp   = ALUOP_SUB;
        PCWrite = ((funct3 == 3'b000) && Z) || ((funct3 == 3'b001) && !Z);
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    unique case (op)
      OP_STORE:  ImmSrc = IMM_S;
      OP_BRANCH: ImmSrc = IMM_B;
      OP_JAL:    ImmSrc = IMM_J;
      default:   ImmSrc = IMM_I;
    endcase
  end

  decodificador_ula uDecUla (
    .aluOp_i      (aluOp),
    .funct3_i     (funct3),
    .op5_i        (op[5]),
    .funct7b5_i   (funct7b5),
    .ulaControl_o (ULAControl)
  );

endmodule
